// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - shared state codes, widths and BCD helper for the whac-a-mole controller
package wam_pkg;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] st_t;

  localparam st_t ST_IDLE  = 3'd0;
  localparam st_t ST_CNTDN = 3'd1;
  localparam st_t ST_PLAY  = 3'd2;
  localparam st_t ST_PAUSE = 3'd3;
  localparam st_t ST_OVER  = 3'd4;

  // Elaboration-time conversion of a 0..99 constant to {tens, ones} BCD
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/wam_ctl_if.sv
// rtl/wam_ctl_if.sv - board button levels in, enables/state/display values out of wam_ctl
interface wam_ctl_if;
  import wam_pkg::*;

  logic       start;
  logic       pse;
  logic       gen_en;
  logic       scr_en;
  logic       clr_scr;
  st_t        st;
  logic [7:0] sec_bcd;
  logic       over;

  modport master (
    output start, pse,
    input  gen_en, scr_en, clr_scr, st, sec_bcd, over
  );

  modport slave (
    input  start, pse,
    output gen_en, scr_en, clr_scr, st, sec_bcd, over
  );

endinterface

// File: rtl/wam_bcd_dn.sv
// rtl/wam_bcd_dn.sv - two-digit BCD down counter with load, decrement and zero flag
module wam_bcd_dn #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] q,
  output logic       zero
);

  assign zero = (q == 8'h00);

  // Saturates at 00; ones borrow from tens
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (dec && !zero) begin
      if (q[3:0] == 4'd0) begin
        q <= {q[7:4] - 4'd1, 4'd9};
      end else begin
        q <= {q[7:4], q[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/wam_ctl.sv
// rtl/wam_ctl.sv - game-round sequencer and seconds timer; WAM_CTL_PAUSE_EN enables PAUSE
module wam_ctl
  import wam_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int ROUND_SEC = 60,
  parameter int CD_SEC    = 3
) (
  input  logic     clk,
  input  logic     clr_n,
  wam_ctl_if.slave bus
);

  localparam int             CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  WRAP      = CW'(TICK_DIV - 1);
  localparam logic [7:0]     ROUND_BCD = to_bcd(ROUND_SEC);
  localparam logic [7:0]     CD_BCD    = to_bcd(CD_SEC);

  st_t           state;
  st_t           state_nx;
  logic          start_d1, start_d2, pse_d1, pse_d2;
  logic          start_edge, pse_edge;
  logic [CW-1:0] pcnt;
  logic          wrap, run, pse_hit, tick;
  logic [7:0]    sec;
  logic          sec_zero, sec_one;
  logic          enter_cd, load, dec;
  logic [7:0]    load_val;
  logic          gen_en_nx, clr_scr_nx, over_nx;
  logic          gen_en_q, clr_scr_q, over_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      start_d1 <= 1'b0;
      start_d2 <= 1'b0;
      pse_d1   <= 1'b0;
      pse_d2   <= 1'b0;
    end else begin
      start_d1 <= bus.start;
      start_d2 <= start_d1;
      pse_d1   <= bus.pse;
      pse_d2   <= pse_d1;
    end
  end

  assign start_edge = start_d1 & ~start_d2;
`ifdef WAM_CTL_PAUSE_EN
  assign pse_edge = pse_d1 & ~pse_d2;
`else
  logic unused_pse;
  assign unused_pse = pse_d1 ^ pse_d2;
  assign pse_edge   = 1'b0;
`endif

  assign wrap    = (pcnt == WRAP);
  assign run     = (state == ST_CNTDN) || (state == ST_PLAY);
  assign pse_hit = (state == ST_PLAY) && pse_edge;
  // A pause request wins over a tick; the wrap value is kept so the tick fires on resume
  assign tick    = run && wrap && !pse_hit;
  assign sec_one = (sec == 8'h01);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pcnt <= '0;
    end else if (enter_cd || tick) begin
      pcnt <= '0;
    end else if (run && !wrap) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= ST_IDLE;
      gen_en_q  <= 1'b0;
      clr_scr_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      gen_en_q  <= gen_en_nx;
      clr_scr_q <= clr_scr_nx;
      over_q    <= over_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_edge) state_nx = ST_CNTDN;
      ST_CNTDN: if (tick && sec_one) state_nx = ST_PLAY;
      ST_PLAY: begin
        if (pse_hit)              state_nx = ST_PAUSE;
        else if (tick && sec_one) state_nx = ST_OVER;
      end
      ST_PAUSE: if (pse_edge) state_nx = ST_PLAY;
      ST_OVER:  if (start_edge) state_nx = ST_CNTDN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    enter_cd   = (state_nx == ST_CNTDN) && (state != ST_CNTDN);
    gen_en_nx  = (state_nx == ST_PLAY);
    over_nx    = (state_nx == ST_OVER);
    clr_scr_nx = enter_cd;
    load       = 1'b0;
    load_val   = ROUND_BCD;
    if (enter_cd) begin
      load     = 1'b1;
      load_val = CD_BCD;
    end else if ((state == ST_CNTDN) && (state_nx == ST_PLAY)) begin
      load     = 1'b1;
    end else if ((state_nx == ST_IDLE) && (state != ST_IDLE)) begin
      load     = 1'b1;
    end
    dec = tick && !sec_zero && !load;
  end

  wam_bcd_dn #(
    .RST_VAL (ROUND_BCD)
  ) u_sec (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .q        (sec),
    .zero     (sec_zero)
  );

  assign bus.st      = state;
  assign bus.sec_bcd = sec;
  assign bus.gen_en  = gen_en_q;
  assign bus.scr_en  = gen_en_q;
  assign bus.clr_scr = clr_scr_q;
  assign bus.over    = over_q;

endmodule

// File: tb/tb_wam_ctl.sv
// tb/tb_wam_ctl.sv - randomized and directed bench for wam_ctl (ROUND_SEC 5 and 12 side by side)
module tb_wam_ctl;

  localparam int TD = 4;
  localparam int CD = 3;
`ifdef WAM_CTL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr_n;
  logic start_lv, pse_lv;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wam_ctl_if ifa ();
  wam_ctl_if ifb ();

  assign ifa.start = start_lv;
  assign ifa.pse   = pse_lv;
  assign ifb.start = start_lv;
  assign ifb.pse   = pse_lv;

  wam_ctl #(.TICK_DIV(TD), .ROUND_SEC(5),  .CD_SEC(CD)) dut_a (.clk(clk), .clr_n(clr_n), .bus(ifa));
  wam_ctl #(.TICK_DIV(TD), .ROUND_SEC(12), .CD_SEC(CD)) dut_b (.clk(clk), .clr_n(clr_n), .bus(ifb));

  logic [2:0] o_st[2];
  logic [7:0] o_sec[2];
  logic       o_gen[2], o_scr[2], o_clr[2], o_over[2];

  assign o_st[0]   = ifa.st;      assign o_st[1]   = ifb.st;
  assign o_sec[0]  = ifa.sec_bcd; assign o_sec[1]  = ifb.sec_bcd;
  assign o_gen[0]  = ifa.gen_en;  assign o_gen[1]  = ifb.gen_en;
  assign o_scr[0]  = ifa.scr_en;  assign o_scr[1]  = ifb.scr_en;
  assign o_clr[0]  = ifa.clr_scr; assign o_clr[1]  = ifb.clr_scr;
  assign o_over[0] = ifa.over;    assign o_over[1] = ifb.over;

  // Model: mode 0..4 = idle/countdown/play/pause/over; e = elapsed active cycles in the phase
  int rnd[2] = '{5, 12};
  int m_mode[2];
  int m_e[2];
  bit m_clr[2];
  bit sh1, sh2, ph1, ph2;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_e[i]    = 0;
      m_clr[i]  = 1'b0;
    end
    sh1 = 1'b0; sh2 = 1'b0; ph1 = 1'b0; ph2 = 1'b0;
  endtask

  task automatic model_step();
    bit se, pe;
    if (!clr_n) begin
      model_reset();
      return;
    end
    se = sh1 && !sh2;
    pe = PAUSE_EN && ph1 && !ph2;
    for (int i = 0; i < 2; i++) begin
      m_clr[i] = 1'b0;
      case (m_mode[i])
        0, 4: if (se) begin m_mode[i] = 1; m_e[i] = 0; m_clr[i] = 1'b1; end
        1: begin
          m_e[i]++;
          if (m_e[i] == CD * TD) begin m_mode[i] = 2; m_e[i] = 0; end
        end
        2: begin
          if (pe) begin
            if (m_e[i] % TD != TD - 1) m_e[i]++;
            m_mode[i] = 3;
          end else begin
            m_e[i]++;
            if (m_e[i] == rnd[i] * TD) m_mode[i] = 4;
          end
        end
        3: if (pe) m_mode[i] = 2;
        default: m_mode[i] = 0;
      endcase
    end
    sh2 = sh1; sh1 = start_lv;
    ph2 = ph1; ph1 = pse_lv;
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int exp_sec(input int i);
    case (m_mode[i])
      0:       return bcd(rnd[i]);
      1:       return bcd(CD - m_e[i] / TD);
      2, 3:    return bcd(rnd[i] - m_e[i] / TD);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    string n;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? "a" : "b";
      chk({n, ".st"},      32'(o_st[i]),   32'(m_mode[i]));
      chk({n, ".sec_bcd"}, 32'(o_sec[i]),  32'(exp_sec(i)));
      chk({n, ".gen_en"},  32'(o_gen[i]),  32'(m_mode[i] == 2));
      chk({n, ".scr_en"},  32'(o_scr[i]),  32'(m_mode[i] == 2));
      chk({n, ".clr_scr"}, 32'(o_clr[i]),  32'(m_clr[i]));
      chk({n, ".over"},    32'(o_over[i]), 32'(m_mode[i] == 4));
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step_cycle();
  endtask

  task automatic pulse_start();
    start_lv = 1'b1;
    step_cycle();
    start_lv = 1'b0;
  endtask

  task automatic pulse_pse();
    pse_lv = 1'b1;
    step_cycle();
    pse_lv = 1'b0;
  endtask

  task automatic wait_play_phase(input int ph);
    int n;
    n = 0;
    while (!(m_mode[0] == 2 && m_e[0] % TD == ph) && n < 200) begin
      step_cycle();
      n++;
    end
    chk("wait_play_phase_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n    = 1'b0;
    start_lv = 1'b0;
    pse_lv   = 1'b0;
    model_reset();
    run(2);
    clr_n = 1'b1;
    run(20);
    chk("idle_st",     32'(ifa.st),      32'd0);
    chk("idle_sec_a",  32'(ifa.sec_bcd), 32'h05);
    chk("idle_gen",    32'(ifa.gen_en),  32'd0);
    chk("idle_sec_b",  32'(ifb.sec_bcd), 32'h12);

    pulse_start();
    step_cycle();
    chk("start_st",    32'(ifa.st),      32'd1);
    chk("start_clr",   32'(ifa.clr_scr), 32'd1);
    chk("start_sec",   32'(ifa.sec_bcd), 32'h03);
    step_cycle();
    chk("clr_one_cyc", 32'(ifa.clr_scr), 32'd0);
    run(11);
    chk("play_st",     32'(ifa.st),      32'd2);
    chk("play_sec",    32'(ifa.sec_bcd), 32'h05);
    chk("play_gen",    32'(ifa.gen_en),  32'd1);
    run(12);
    chk("borrow_b",    32'(ifb.sec_bcd), 32'h09);
    chk("mid_a",       32'(ifa.sec_bcd), 32'h02);
    run(8);
    chk("over_st",     32'(ifa.st),      32'd4);
    chk("over_flag",   32'(ifa.over),    32'd1);
    chk("over_sec",    32'(ifa.sec_bcd), 32'h00);
    chk("over_gen",    32'(ifa.gen_en),  32'd0);
    chk("b_still_sec", 32'(ifb.sec_bcd), 32'h07);

    // Second game with start held through countdown and play, pause early in play
    start_lv = 1'b1;
    run(2);
    chk("restart_st",  32'(ifa.st),      32'd1);
    chk("restart_clr", 32'(ifa.clr_scr), 32'd1);
    run(13);
    pulse_pse();
    run(4);
    start_lv = 1'b0;
    run(2);
    start_lv = 1'b1;
    run(4);
    chk("pause_st",    32'(ifa.st),      PAUSE_EN ? 32'd3 : 32'd2);
    pulse_pse();
    start_lv = 1'b0;
    run(40);

    // Third game: pause request landing on a tick cycle
    pulse_start();
    wait_play_phase(TD - 2);
    pulse_pse();
    run(6);
    pulse_pse();
    run(30);

    // Random button activity
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) start_lv = ~start_lv;
      if ($urandom_range(0, 5) == 0) pse_lv = ~pse_lv;
      step_cycle();
    end
    start_lv = 1'b0;
    pse_lv   = 1'b0;

    // Asynchronous abort mid-play
    clr_n = 1'b0;
    step_cycle();
    clr_n = 1'b1;
    run(2);
    pulse_start();
    run(18);
    #2;
    clr_n = 1'b0;
    #1;
    chk("abort_st",    32'(ifa.st),      32'd0);
    chk("abort_sec_a", 32'(ifa.sec_bcd), 32'h05);
    chk("abort_sec_b", 32'(ifb.sec_bcd), 32'h12);
    chk("abort_gen",   32'(ifa.gen_en),  32'd0);
    chk("abort_clr",   32'(ifa.clr_scr), 32'd0);
    chk("abort_over",  32'(ifa.over),    32'd0);
    model_reset();
    run(2);
    clr_n = 1'b1;
    run(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wam_ctl.md
# wam_ctl

Game-round sequencer for the whac-a-mole design. Owns the game state machine (idle, countdown, play, pause, game-over) and a seconds timer, and drives the enables that gate the mole generator and score counter. Sits between the board buttons and the generator/score/display blocks. Exports remaining time as two BCD digits for the digital-tube display.

## Interface

Parameters:
- TICK_DIV, 100_000_000, clk cycles per one-second tick (≥2)
- ROUND_SEC, 60, play duration in seconds (1..99)
- CD_SEC, 3, pre-game countdown in seconds (1..9)

Ports:
- clk  in  1  system clock; one clock domain
- clr_n  in  1  reset, asynchronous, active-low
- start  in  1  start button level, debounced and synchronous to clk
- pse  in  1  pause button level, debounced and synchronous to clk
- gen_en  out  1  mole generator enable
- scr_en  out  1  score counter enable
- clr_scr  out  1  one-cycle score/generator clear pulse
- st  out  3  current state code
- sec_bcd  out  8  remaining seconds, {tens, ones} BCD
- over  out  1  game-over flag

## Operation

- Rising edges on start and pse come from a one-cycle-delayed copy; the edge is seen the cycle after the level rises. A held button gives exactly one edge.
- Prescaler counts 0..TICK_DIV-1 and produces tick in the wrap cycle. It runs only in CNTDN and PLAY, holds in PAUSE, and clears to 0 on entry to CNTDN.
- States (st): IDLE=0, CNTDN=1, PLAY=2, PAUSE=3, OVER=4. Codes 5–7 go to IDLE on the next cycle.
- IDLE: sec_bcd=ROUND_SEC. start edge → CNTDN, load sec_bcd=CD_SEC, pulse clr_scr.
- CNTDN: tick decrements sec_bcd. Tick with sec_bcd==1 → PLAY, load ROUND_SEC.
- PLAY: gen_en=scr_en=1. Tick decrements sec_bcd. Tick with sec_bcd==1 → OVER, sec_bcd=0. pse edge → PAUSE.
- PAUSE: gen_en=scr_en=0, timer frozen. pse edge → PLAY, resuming the prescaler from its held count.
- OVER: over=1, sec_bcd=0. start edge → CNTDN, load CD_SEC, pulse clr_scr.
- start edges are ignored in CNTDN, PLAY and PAUSE. pse edges are ignored outside PLAY and PAUSE.
- Simultaneous events in PLAY: a pse edge beats a tick. The tick is discarded and the prescaler holds at its wrap value. The decrement is taken on the first cycle after resume.
- BCD decrement: ones==0 → ones=9 and tens−1. sec_bcd never goes below 00.

## Timing

- Reset values: st=IDLE, sec_bcd=BCD(ROUND_SEC), gen_en=scr_en=clr_scr=over=0, prescaler=0, edge registers=0.
- All outputs are registered. They reflect the new state in the cycle after the transition condition.
- Start latency: start rises in cycle n → edge in n+1 → st=CNTDN and clr_scr=1 in n+2.
- CNTDN lasts exactly CD_SEC×TICK_DIV cycles. PLAY lasts ROUND_SEC×TICK_DIV cycles, excluding paused cycles.
- clr_scr is high for exactly one cycle per game start.
- Deasserting clr_n mid-game aborts immediately to reset values, with no clr_scr pulse.

## Configuration

- WAM_CTL_PAUSE_EN defined: PAUSE state and the pse input are active as described.
- WAM_CTL_PAUSE_EN undefined: the pse port remains but is ignored, PAUSE is unreachable, and the prescaler never holds in PLAY.

## Structure

- The shared package wam_pkg holds the state localparams (IDLE..OVER), the 3-bit state width, and a function converting a binary constant to 8-bit BCD, used for ROUND_SEC and CD_SEC loads.
- One sub-module, wam_bcd_dn: a 2-digit BCD down counter with synchronous load, decrement enable and a zero flag. wam_ctl instantiates it once for sec_bcd.

## Test plan

Common settings: TICK_DIV=4, ROUND_SEC=5, CD_SEC=3.

- Reset, then idle for 20 cycles → st=0, sec_bcd=8'h05, all enables 0.
- Start pulse → clr_scr high exactly one cycle, st=1, sec_bcd 03→02→01 every 4 cycles, then st=2, sec_bcd=05, gen_en=scr_en=1.
- Full round with no pause → after 20 PLAY cycles st=4, over=1, sec_bcd=00, gen_en=0. Second start → new clr_scr pulse, st=1.
- pse edge two cycles into PLAY, held paused 10 cycles, then pse edge → st=3 with sec_bcd frozen, then resume. PLAY total is still 20 active cycles. Repeat with the pse edge on a tick cycle → tick deferred to the first cycle after resume.
- start held high throughout PLAY, plus start pulses in CNTDN/PAUSE → no state change, no clr_scr.
- ROUND_SEC=12: sec_bcd sequence 12→11→10→09 checks the BCD borrow. clr_n low mid-PLAY → all outputs at reset values asynchronously. Build without WAM_CTL_PAUSE_EN → pse has no effect.
